// File: rtl/bcm_pkg.sv
// Shared definitions for the bcm code packer: default sizes and control FSM states.
package bcm_pkg;

  localparam int CODE_W_DEF = 2;
  localparam int N_DEF      = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    PEND  = 2'd2
  } state_t;

endpackage

// File: rtl/bcm_out_reg.sv
// Valid/ready holding register for the packed word and its length.
module bcm_out_reg #(
  parameter int W  = 8,
  parameter int LW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_word,
  input  logic [LW-1:0] load_len,
  input  logic          word_ready,
  output logic [W-1:0]  word_out,
  output logic [LW-1:0] word_len,
  output logic          word_valid
);

  // Load a new word when asked; otherwise drop valid once downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_out   <= '0;
      word_len   <= '0;
      word_valid <= 1'b0;
    end else if (load) begin
      word_out   <= load_word;
      word_len   <= load_len;
      word_valid <= 1'b1;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bcm_pack.sv
// Packs a stream of bcm codes into N-code words, with flush of partial words.
//
// state | meaning
// EMPTY | no codes held, no pending flush
// FILL  | 1..N-1 codes held in acc, no pending flush
// PEND  | flush requested while the output register was busy
module bcm_pack
  import bcm_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CODE_W-1:0]       code_in,
  input  logic                    code_valid,
  output logic                    code_ready,
  input  logic                    flush,
  output logic [N*CODE_W-1:0]     word_out,
  output logic [$clog2(N+1)-1:0]  word_len,
  output logic                    word_valid,
  input  logic                    word_ready
);

  localparam int W  = N * CODE_W;
  localparam int LW = $clog2(N + 1);

  state_t          state, state_nxt;
  logic [W-1:0]    acc, acc_nxt, acc_wr;
  logic [LW-1:0]   cnt, cnt_nxt, cnt_acc;
  logic            flush_pend, pend_nxt;
  logic            out_free, accept, complete;
  logic            load;
  logic [W-1:0]    load_word;
  logic [LW-1:0]   load_len;

  assign flush_pend = (state == PEND);
  assign out_free   = !word_valid || word_ready;
  assign code_ready = !rst && !flush_pend && ((cnt != LW'(N - 1)) || out_free);
  assign accept     = code_valid && code_ready;
  assign complete   = accept && (cnt == LW'(N - 1));
  assign cnt_acc    = cnt + LW'(accept);

  // Accumulator image with the accepted code placed at slot cnt.
  always_comb begin
    acc_wr = acc;
    for (int k = 0; k < N; k++) begin
      if (accept && (int'(cnt) == k)) acc_wr[k*CODE_W +: CODE_W] = code_in;
    end
  end

  // Next-state, accumulator update and output-register load decisions.
  always_comb begin
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    pend_nxt  = 1'b0;
    load      = 1'b0;
    load_word = '0;
    load_len  = '0;
    if (state == PEND) begin
      // No codes are accepted here, so acc/cnt are exactly the pending partial word.
      if (out_free) begin
        load      = 1'b1;
        load_word = acc;
        load_len  = cnt;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end else begin
        pend_nxt  = 1'b1;
      end
    end else if (complete) begin
      // A full word supersedes any flush in the same cycle; nothing remains to flush.
      load      = 1'b1;
      load_word = acc_wr;
      load_len  = LW'(N);
      acc_nxt   = '0;
      cnt_nxt   = '0;
    end else if (flush && (cnt_acc != '0)) begin
      if (out_free) begin
        load      = 1'b1;
        load_word = acc_wr;
        load_len  = cnt_acc;
        acc_nxt   = '0;
        cnt_nxt   = '0;
      end else begin
        acc_nxt   = acc_wr;
        cnt_nxt   = cnt_acc;
        pend_nxt  = 1'b1;
      end
    end else begin
      acc_nxt = acc_wr;
      cnt_nxt = cnt_acc;
    end

    if (pend_nxt)            state_nxt = PEND;
    else if (cnt_nxt == '0)  state_nxt = EMPTY;
    else                     state_nxt = FILL;
  end

  // Control state, fill count and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  bcm_out_reg #(
    .W  (W),
    .LW (LW)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_word  (load_word),
    .load_len   (load_len),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_len   (word_len),
    .word_valid (word_valid)
  );

endmodule

// File: tb/tb_bcm_pack.sv
// Directed self-checking bench for bcm_pack with N=4, CODE_W=2.
module tb_bcm_pack;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic       flush;
  logic [7:0] word_out;
  logic [2:0] word_len;
  logic       word_valid;
  logic       word_ready;

  int n_checks = 0;
  int n_fails  = 0;

  bcm_pack #(.N(4), .CODE_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .flush      (flush),
    .word_out   (word_out),
    .word_len   (word_len),
    .word_valid (word_valid),
    .word_ready (word_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c);
    code_in    = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  logic [1:0] bp_codes [8];
  int         accepted;

  initial begin
    bp_codes = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01, 2'b11};
    rst = 1'b1; code_in = '0; code_valid = 1'b0; flush = 1'b0; word_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", word_valid, 0);
    chk("rst_word",  word_out, 0);
    chk("rst_len",   word_len, 0);
    chk("rst_ready", code_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", code_ready, 1);

    // Basic pack
    send(2'b01); send(2'b11); send(2'b00);
    chk("basic_no_early_valid", word_valid, 0);
    send(2'b10);
    chk("basic_valid", word_valid, 1);
    chk("basic_word",  word_out, 8'h8D);
    chk("basic_len",   word_len, 4);
    tick();
    chk("basic_one_cycle", word_valid, 0);

    // Partial flush
    send(2'b01); send(2'b11);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_valid", word_valid, 1);
    chk("flush_word",  word_out, 8'h0D);
    chk("flush_len",   word_len, 2);
    chk("flush_cnt",   dut.cnt, 0);
    tick();
    chk("flush_drained", word_valid, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("empty_flush_noop", word_valid, 0);

    // Code accepted together with flush
    send(2'b11);
    code_in = 2'b10; code_valid = 1'b1; flush = 1'b1;
    tick();
    code_valid = 1'b0; flush = 1'b0;
    chk("simul_word",  word_out, 8'h0B);
    chk("simul_len",   word_len, 2);
    chk("simul_valid", word_valid, 1);
    tick();

    // Backpressure
    word_ready = 1'b0;
    accepted   = 0;
    code_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      code_in = bp_codes[accepted];
      #1;
      if (code_ready) accepted++;
      tick();
    end
    code_in = bp_codes[accepted & 7];
    #1;
    chk("bp_accepted", accepted, 7);
    chk("bp_blocked",  code_ready, 0);
    chk("bp_word",     word_out, 8'h39);
    chk("bp_held",     word_valid, 1);
    word_ready = 1'b1;
    #1;
    chk("bp_ready_on_drain", code_ready, 1);
    tick();
    code_valid = 1'b0; word_ready = 1'b0;
    chk("bp_word2", word_out, 8'hDA);
    chk("bp_len2",  word_len, 4);
    tick();
    chk("bp_hold_word", word_out, 8'hDA);
    chk("bp_hold_valid", word_valid, 1);
    word_ready = 1'b1; tick();
    chk("bp_drained", word_valid, 0);

    // Blocked flush
    word_ready = 1'b0;
    send(2'b00); send(2'b01); send(2'b10); send(2'b11);
    send(2'b11); send(2'b01);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pend_ready", code_ready, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("pend_held_word", word_out, 8'hE4);
    chk("pend_held_len",  word_len, 4);
    word_ready = 1'b1;
    #1;
    chk("pend_ready_draining", code_ready, 0);
    tick();
    chk("pend_word",  word_out, 8'h07);
    chk("pend_len",   word_len, 2);
    chk("pend_valid", word_valid, 1);
    tick();
    chk("pend_no_second", word_valid, 0);
    tick();
    chk("pend_still_none", word_valid, 0);
    chk("pend_ready_back", code_ready, 1);

    // Reset mid-operation
    word_ready = 1'b0;
    send(2'b11); send(2'b11); send(2'b11); send(2'b11);
    send(2'b11); send(2'b11); send(2'b11);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", code_ready, 0);
    tick();
    chk("rst_mid_valid", word_valid, 0);
    chk("rst_mid_word",  word_out, 0);
    chk("rst_mid_len",   word_len, 0);
    rst = 1'b0; word_ready = 1'b1;
    send(2'b10); send(2'b00); send(2'b01); send(2'b10);
    chk("post_rst_word",  word_out, 8'h92);
    chk("post_rst_len",   word_len, 4);
    chk("post_rst_valid", word_valid, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bcm_pack.md
BCM_PACK -- requirements
Module: bcm_pack

Interface
REQ-001 Parameter: N, default 4, number of 2-bit codes packed per output word (N >= 2).
REQ-002 Parameter: CODE_W, default 2, width of one input code, matching the bcm output width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 code_in  input  CODE_W  2-bit code from the upstream bcm stage (its o output).
REQ-006 code_valid  input  1  code_in is valid this cycle.
REQ-007 code_ready  output  1  block accepts code_in this cycle; a code transfers when code_valid && code_ready.
REQ-008 flush  input  1  single-cycle request to emit the partially filled word.
REQ-009 word_out  output  N*CODE_W  packed word; code k occupies bits [2k+1:2k], so the first code is in the LSBs.
REQ-010 word_len  output  $clog2(N+1)  number of valid codes in word_out, range 1..N.
REQ-011 word_valid  output  1  word_out/word_len are valid and held stable until accepted.
REQ-012 word_ready  input  1  downstream accepts the word; a transfer occurs when word_valid && word_ready.

Function
REQ-013 Two storage elements: accumulator acc holding 0..N-1 codes with count cnt, and an output register (word_out/word_len/word_valid).
REQ-014 Accepted code handling: the code is written at slot cnt of acc, and cnt increments.
REQ-015 Word completion: when an accepted code is the Nth, {code, acc} moves to the output register in the same edge with word_len=N, and cnt returns to 0.
REQ-016 The output register is free when !word_valid || word_ready (a same-cycle drain counts as free).
REQ-017 code_ready = !rst && !flush_pend && (cnt != N-1 || output register free); code_ready is combinational, with no dependency on code_valid.
REQ-018 Flush with the output register free: acc (including a code accepted in the same cycle) moves to the output register; word_len = cnt (+1 if a code was accepted); unused upper bits are 0; cnt clears.
REQ-019 Flush while the output register is occupied and not draining: flush_pend is set; code_ready is 0 while it is set; the flush executes on the first cycle the output register becomes free.
REQ-020 Flush with cnt==0 and no code accepted is a no-op; no zero-length word is ever emitted.
REQ-021 Flush arriving while flush_pend is already set is absorbed, with no second word.
REQ-022 Control FSM states:
  - EMPTY: cnt==0, no pend.
  - FILL: 0<cnt<N, no pend.
  - PEND: flush_pend set.
REQ-023 FSM transitions:
  - EMPTY->FILL on accept.
  - FILL->EMPTY on completion or executed flush.
  - FILL->PEND on a blocked flush.
  - PEND->EMPTY when the output register frees.
REQ-024 Latency: the word is visible on word_out the cycle after the completing code or the flush is accepted.
REQ-025 Throughput: one code per cycle sustained when word_ready is held high.
REQ-026 word_out and word_len shall not change while word_valid && !word_ready.

Reset
REQ-027 On rst high at a clock edge, the block shall clear cnt, acc, flush_pend, word_out, word_len and word_valid to 0, and the FSM to EMPTY.
REQ-028 Reset mid-word discards the partial acc and any held word, without emitting them.
REQ-029 code_ready is 0 while rst is high.

Structure
REQ-030 Shared package bcm_pkg shall hold CODE_W, default N, and the FSM state typedef (EMPTY, FILL, PEND).
REQ-031 One sub-module is natural: bcm_out_reg, a valid/ready holding register for word_out/word_len.

Verification
REQ-032 Basic pack: codes 01,11,00,10 with word_ready=1 -> word_out=8'h8D, word_len=4, word_valid high for 1 cycle, 1 cycle after the 4th code.
REQ-033 Partial flush: codes 01,11, then flush -> word_out=8'h0D, word_len=2; cnt returns to 0.
REQ-034 Backpressure: word_ready=0 with code_valid held -> 7 codes accepted, code_ready=0 on the 8th; word_ready=1 for 1 cycle -> the 8th code is accepted that cycle.
REQ-035 Simultaneous events: code 10 accepted together with flush at cnt=1 (acc=11) -> word_out=8'h0B, word_len=2.
REQ-036 Blocked flush: output held with cnt=2 and flush pulsed -> code_ready=0; when word_ready rises, the partial word is emitted next with word_len=2.
REQ-037 Reset mid-operation: rst after 3 codes with a word held -> all outputs 0; the next 4 codes produce a fresh word with no residue.
